// File: rtl/apb_master_pkg.sv
// Shared types and default address-map constants for the APB request master.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } apb_state_e;

  // Peripheral window as laid out in the SoC address map.
  localparam logic [31:0] APB_WIN_START   = 32'h1A10_0000;
  localparam logic [31:0] APB_WIN_END     = 32'h1A11_FFFF;
  localparam int unsigned APB_TIMEOUT_DEF = 256;

endpackage

// File: rtl/APB_BUS.sv
// APB bus bundle shared by the request master and the peripheral decoder.
interface APB_BUS #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; expired_o flags the last permitted cycle.
module apb_timeout_cnt #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (LIMIT == 0) begin : g_off
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int unsigned   CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;

    // Saturates at LAST so a stuck enable can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       cnt_q <= '0;
      else if (clr_i)                   cnt_q <= '0;
      else if (en_i && (cnt_q != LAST)) cnt_q <= cnt_q + 1'b1;
    end

    assign expired_o = (cnt_q == LAST);
  end

endmodule

// File: rtl/apb_req_master.sv
// req/gnt/rvalid to APB bridge with address-window decode and pready timeout.
module apb_req_master
  import apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] WIN_START = APB_ADDR_WIDTH'(APB_WIN_START),
  parameter logic [APB_ADDR_WIDTH-1:0] WIN_END   = APB_ADDR_WIDTH'(APB_WIN_END),
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  APB_BUS.Master                    apb_master
);

  typedef struct packed {
    logic                      vld;
    logic                      err;
    logic [APB_DATA_WIDTH-1:0] rdata;
  } rsp_t;

  apb_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      we_q;
  rsp_t                      rsp_q, rsp_d;
  logic                      in_win, expired, done;

  assign in_win = (addr_i >= WIN_START) && (addr_i <= WIN_END);
  assign gnt_o  = (state_q == IDLE) && req_i;
  assign done   = (state_q == ACCESS) && apb_master.pready;

  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == SETUP),
    .en_i      ((state_q == ACCESS) && !apb_master.pready),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rsp_d   = '0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = in_win ? SETUP : DECERR;
          // Decode errors answer straight from the grant cycle.
          rsp_d.vld = !in_win;
          rsp_d.err = !in_win;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // A completing pready beats a coincident timeout.
        if (done) begin
          state_d     = IDLE;
          rsp_d.vld   = 1'b1;
          rsp_d.err   = apb_master.pslverr;
          rsp_d.rdata = we_q ? '0 : apb_master.prdata;
        end else if (expired) begin
          state_d   = IDLE;
          rsp_d.vld = 1'b1;
          rsp_d.err = 1'b1;
        end
      end
      DECERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rsp_q   <= '0;
    end else begin
      rsp_q <= rsp_d;
      if (gnt_o) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        we_q    <= we_i;
      end
    end
  end

  assign rvalid_o = rsp_q.vld;
  assign err_o    = rsp_q.err;
  assign rdata_o  = rsp_q.rdata;

  // Address/data track the request registers so they never glitch to 0 in IDLE.
  assign apb_master.paddr   = addr_q;
  assign apb_master.pwdata  = wdata_q;
  assign apb_master.pwrite  = we_q;
  assign apb_master.psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_master.penable = (state_q == ACCESS);

endmodule
